// File: rtl/mux2x1_rr_arbiter.sv
// mux2x1_rr_arbiter
//   Round-robin arbiter and sequencer in front of a shared 2:1 mux path.
//   Two requesters offer WIDTH-bit words with valid/ready handshakes. The
//   winner's word is steered into a one-entry registered output stage that is
//   presented downstream with its own valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   a_valid    requester A has a word on a_data
//   a_data     requester A word
//   a_ready    A's word is accepted this cycle (combinational)
//   b_valid    requester B has a word on b_data
//   b_data     requester B word
//   b_ready    B's word is accepted this cycle (combinational)
//   out_valid  out_data holds a valid word
//   out_data   registered winning word
//   out_sel    source of out_data (0 = A, 1 = B)
//   out_ready  consumer takes out_data this cycle
module mux2x1_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             prio_r;        // 0 favours A on a tie, 1 favours B
  logic [WIDTH-1:0] out_data_r;
  logic             out_sel_r;

  logic             can_accept_s;
  logic             winner_valid_s;
  logic             winner_s;
  logic [WIDTH-1:0] winner_data_s;

  // The output slot can take a word when empty or when it drains this cycle.
  assign can_accept_s = (state_r == EMPTY) || out_ready;

  // Winner selection: tie goes to prio, a lone requester always wins.
  always_comb begin
    winner_valid_s = 1'b0;
    winner_s       = prio_r;
    if (can_accept_s) begin
      if (a_valid && b_valid) begin
        winner_valid_s = 1'b1;
        winner_s       = prio_r;
      end else if (a_valid) begin
        winner_valid_s = 1'b1;
        winner_s       = 1'b0;
      end else if (b_valid) begin
        winner_valid_s = 1'b1;
        winner_s       = 1'b1;
      end else begin
        winner_valid_s = 1'b0;
        winner_s       = prio_r;
      end
    end else begin
      winner_valid_s = 1'b0;
      winner_s       = prio_r;
    end
  end

  // Steer the winning word through the 2:1 mux.
  always_comb begin
    winner_data_s = a_data;
    if (winner_s) begin
      winner_data_s = b_data;
    end else begin
      winner_data_s = a_data;
    end
  end

  // winner_valid_s already implies can_accept and the matching valid.
  assign a_ready = winner_valid_s && (winner_s == 1'b0);
  assign b_ready = winner_valid_s && (winner_s == 1'b1);

  // Output-stage next state: an accept fills the slot, a drain without a
  // replacement empties it, otherwise the slot holds.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (winner_valid_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (!out_ready) begin
          state_next_s = FULL;
        end else if (winner_valid_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Data/select capture and priority rotation on every accept; a lone grant
  // also hands priority to the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r <= {WIDTH{1'b0}};
      out_sel_r  <= 1'b0;
      prio_r     <= 1'b0;
    end else if (winner_valid_s) begin
      out_data_r <= winner_data_s;
      out_sel_r  <= winner_s;
      prio_r     <= ~winner_s;
    end else begin
      out_data_r <= out_data_r;
      out_sel_r  <= out_sel_r;
      prio_r     <= prio_r;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
module tb_mux2x1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sel;
  logic       out_ready;

  int pass_cnt;
  int total_cnt;

  mux2x1_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else pass_cnt++;
    total_cnt++; if (out_sel !== 1'b0) $display("FAIL reset_out_sel got %0b exp 0", out_sel); else pass_cnt++;
    total_cnt++; if (a_ready !== 1'b0) $display("FAIL reset_a_ready got %0b exp 0", a_ready); else pass_cnt++;
    total_cnt++; if (b_ready !== 1'b0) $display("FAIL reset_b_ready got %0b exp 0", b_ready); else pass_cnt++;
  endtask

  task automatic test_single_a();
    do_reset();
    a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b0; out_ready = 1'b1;
    #1;
    total_cnt++; if (a_ready !== 1'b1) $display("FAIL single_a_ready got %0b exp 1", a_ready); else pass_cnt++;
    total_cnt++; if (b_ready !== 1'b0) $display("FAIL single_b_ready got %0b exp 0", b_ready); else pass_cnt++;
    tick();
    a_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %0b exp 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h11) $display("FAIL single_out_data got %h exp 11", out_data); else pass_cnt++;
    total_cnt++; if (out_sel !== 1'b0) $display("FAIL single_out_sel got %0b exp 0", out_sel); else pass_cnt++;
    tick();
    // Consumer drained, nothing offered: slot empties, data held.
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL drain_out_valid got %0b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h11) $display("FAIL drain_out_data got %h exp 11", out_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    logic       exp_s;
    do_reset();
    a_valid = 1'b1; a_data = 8'hA0; b_valid = 1'b1; b_data = 8'hB0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_s = (i % 2 == 1) ? 1'b1 : 1'b0;
      exp_d = exp_s ? 8'hB0 : 8'hA0;
      #1;
      total_cnt++; if (a_ready !== ~exp_s || b_ready !== exp_s) $display("FAIL b2b_ready[%0d] got a=%0b b=%0b exp a=%0b b=%0b", i, a_ready, b_ready, ~exp_s, exp_s); else pass_cnt++;
      tick();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== exp_d || out_sel !== exp_s) $display("FAIL b2b_out[%0d] got v=%0b d=%h s=%0b exp v=1 d=%h s=%0b", i, out_valid, out_data, out_sel, exp_d, exp_s); else pass_cnt++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_valid = 1'b1; a_data = 8'h22; b_valid = 1'b0; out_ready = 1'b1;
    tick();
    // Slot holds 0x22 and priority now favours B.
    out_ready = 1'b0;
    a_data = 8'h55; b_valid = 1'b1; b_data = 8'h66;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL stall_ready[%0d] got a=%0b b=%0b exp a=0 b=0", i, a_ready, b_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_sel !== 1'b0) $display("FAIL stall_hold[%0d] got v=%0b d=%h s=%0b exp v=1 d=22 s=0", i, out_valid, out_data, out_sel); else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (b_ready !== 1'b1 || a_ready !== 1'b0) $display("FAIL release_ready got a=%0b b=%0b exp a=0 b=1", a_ready, b_ready); else pass_cnt++;
    tick();
    b_valid = 1'b0; a_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h66 || out_sel !== 1'b1) $display("FAIL release_out got v=%0b d=%h s=%0b exp v=1 d=66 s=1", out_valid, out_data, out_sel); else pass_cnt++;
  endtask

  task automatic test_prio_flip();
    do_reset();
    b_valid = 1'b1; b_data = 8'h33; a_valid = 1'b0; out_ready = 1'b1;
    #1;
    total_cnt++; if (b_ready !== 1'b1 || a_ready !== 1'b0) $display("FAIL lone_b_ready got a=%0b b=%0b exp a=0 b=1", a_ready, b_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_sel !== 1'b1) $display("FAIL lone_b_out got v=%0b d=%h s=%0b exp v=1 d=33 s=1", out_valid, out_data, out_sel); else pass_cnt++;
    a_valid = 1'b1; a_data = 8'h77; b_data = 8'h88;
    #1;
    total_cnt++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL flip_ready got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready); else pass_cnt++;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    total_cnt++; if (out_data !== 8'h77 || out_sel !== 1'b0) $display("FAIL flip_out got d=%h s=%0b exp d=77 s=0", out_data, out_sel); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Make B favoured first so the post-reset A grant proves prio was cleared.
    a_valid = 1'b1; a_data = 8'h44; b_valid = 1'b0; out_ready = 1'b1;
    tick();
    a_valid = 1'b0; out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h44) $display("FAIL pre_rst_out got v=%0b d=%h exp v=1 d=44", out_valid, out_data); else pass_cnt++;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL async_rst_valid got %0b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00 || out_sel !== 1'b0) $display("FAIL async_rst_data got d=%h s=%0b exp d=00 s=0", out_data, out_sel); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    a_valid = 1'b1; a_data = 8'h99; b_valid = 1'b1; b_data = 8'hAA; out_ready = 1'b1;
    #1;
    total_cnt++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL post_rst_ready got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready); else pass_cnt++;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h99 || out_sel !== 1'b0) $display("FAIL post_rst_out got v=%0b d=%h s=%0b exp v=1 d=99 s=0", out_valid, out_data, out_sel); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_backpressure();
    test_prio_flip();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux2x1_rr_arbiter.md
Name: mux2x1_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 2:1 multiplexer path.
- Two requesters (A, B) each offer a WIDTH-bit word with a valid/ready handshake.
- The block decides which requester owns the mux select, steers the winning word into a one-entry registered output stage, and presents it downstream with its own valid/ready handshake.
- Sits between two producers and a single consumer wherever a plain mux2x1 needs fair, flow-controlled select generation.

Parameters:
- WIDTH, 8, data width of each requester word and of out_data.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a word on a_data.
- a_data  input  WIDTH  requester A word.
- a_ready  output  1  A's word is accepted this cycle.
- b_valid  input  1  requester B has a word on b_data.
- b_data  input  WIDTH  requester B word.
- b_ready  output  1  B's word is accepted this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WIDTH  registered winning word.
- out_sel  output  1  source of the current out_data (0 = A, 1 = B).
- out_ready  input  1  consumer takes out_data this cycle.

Behaviour:
- Reset (async, immediate on rst high):
  - out_valid=0, out_data=0, out_sel=0.
  - Internal priority pointer prio=0, meaning A is favoured.
  - Output state is EMPTY.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) || out_ready.
- Winner selection (combinational), evaluated when can_accept:
  - Both valid: winner = prio.
  - Only one valid: that one wins.
  - Neither valid: no winner.
- a_ready = can_accept && a_valid && winner==A. b_ready is symmetric.
  - Ready depends combinationally on valid and out_ready.
  - At most one ready is high in any cycle.
  - Ready is never high without the matching valid.
- Accept (a ready high at the clock edge):
  - out_data <= winner data.
  - out_sel <= winner.
  - out_valid <= 1.
  - prio <= ~winner, so the loser of a tie wins next.
  - A single uncontested grant also flips prio.
- can_accept with no winner: out_valid <= 0 and state goes to EMPTY. out_data and out_sel keep their last value.
- FULL with out_ready=0:
  - out_data and out_sel are held stable.
  - a_ready=b_ready=0.
  - prio is unchanged.
- FULL with out_ready=1 and a winner: the drain and the new accept happen in the same cycle, with no bubble.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N.
- Throughput: one word per cycle with out_ready held high. Continuous dual requests alternate A,B,A,B.
- Fairness: neither requester waits more than one grant while both are continuously valid.
- Requester obligation: hold valid and data until its ready is seen high. The block does not re-check this.
- Reset mid-transfer: any held word is discarded, out_valid drops immediately, and prio returns to A.
- Deassertion of rst is assumed to be synchronous to clk by the system.

Test Plan:
- Reset with all valids low → out_valid=0, out_data=0x00, out_sel=0, a_ready=b_ready=0.
- a_valid=1, a_data=0x11, b_valid=0, out_ready=1 → a_ready=1 that cycle. Next cycle out_valid=1, out_data=0x11, out_sel=0.
- Both valid continuously (a_data=0xA0, b_data=0xB0), out_ready=1 from reset → out_data sequence 0xA0,0xB0,0xA0,0xB0, out_sel 0,1,0,1, exactly one ready high per cycle.
- Output FULL with 0x22, out_ready=0 for 5 cycles with both valids high → a_ready=b_ready=0 throughout, out_data=0x22 held. On out_ready=1, the next word is loaded the following cycle with no gap.
- B alone accepted (0x33), then both valid → A wins the next grant (prio flipped by the uncontested B grant).
- rst pulsed while out_valid=1 holding 0x44 → out_valid=0 immediately, without waiting for clk. After release, both valid → A granted first.
